// File: rtl/demux_1to4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry holding register per channel.
// Optional DEMUX_AUTO_SEL_EN: the destination comes from an internal slot counter instead of {s1,s0}.
module demux_1to4_stream #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         s0,
  input  logic         s1,
  input  logic         sof,
  output logic [W-1:0] ya,
  output logic [W-1:0] yb,
  output logic [W-1:0] yc,
  output logic [W-1:0] yd,
  output logic         ya_valid,
  output logic         yb_valid,
  output logic         yc_valid,
  output logic         yd_valid,
  input  logic         ya_ready,
  input  logic         yb_ready,
  input  logic         yc_ready,
  input  logic         yd_ready
);

  // state | meaning
  // EMPTY | channel register holds no beat
  // FULL  | channel register holds a beat, presented on y<ch>
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  ch_state_t      state_q [4];
  ch_state_t      state_d [4];
  logic [W-1:0]   data_q  [4];
  logic [3:0]     y_ready;
  logic [3:0]     load;
  logic [1:0]     dest;
  logic           in_xfer;

  assign y_ready = {yd_ready, yc_ready, yb_ready, ya_ready};

`ifdef DEMUX_AUTO_SEL_EN
  logic [1:0] slot_q;
  logic       unused_sel;

  assign unused_sel = s0 ^ s1;
  // A start-of-frame beat realigns the slot sequence to channel a.
  assign dest = sof ? 2'd0 : slot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= 2'd0;
    end else if (in_xfer) begin
      slot_q <= dest + 2'd1;
    end
  end
`else
  logic unused_sof;

  assign unused_sof = sof;
  assign dest       = {s1, s0};
`endif

  // Ready looks only at the addressed channel so a stalled sink cannot block the others.
  assign din_ready = (state_q[dest] == EMPTY) || y_ready[dest];
  assign in_xfer   = din_valid && din_ready;

  always_comb begin
    load = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      load[i]    = in_xfer && (dest == 2'(i));
      case (state_q[i])
        EMPTY:   if (load[i]) state_d[i] = FULL;
        FULL:    if (y_ready[i] && !load[i]) state_d[i] = EMPTY;
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) state_q[i] <= EMPTY;
    end else begin
      for (int i = 0; i < 4; i++) state_q[i] <= state_d[i];
    end
  end

  // Data is cleared on reset so outputs read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) data_q[i] <= din;
      end
    end
  end

  assign ya       = data_q[0];
  assign yb       = data_q[1];
  assign yc       = data_q[2];
  assign yd       = data_q[3];
  assign ya_valid = (state_q[0] == FULL);
  assign yb_valid = (state_q[1] == FULL);
  assign yc_valid = (state_q[2] == FULL);
  assign yd_valid = (state_q[3] == FULL);

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed, table-driven bench for demux_1to4_stream, plus hand-written reset and auto-select sequences.
module tb_demux_1to4_stream;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid, din_ready, s0, s1, sof;
  logic [W-1:0] ya, yb, yc, yd;
  logic         ya_valid, yb_valid, yc_valid, yd_valid;
  logic         ya_ready, yb_ready, yc_ready, yd_ready;

  int n_checks = 0;
  int n_fail   = 0;

  demux_1to4_stream #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .s0(s0), .s1(s1), .sof(sof),
    .ya(ya), .yb(yb), .yc(yc), .yd(yd),
    .ya_valid(ya_valid), .yb_valid(yb_valid), .yc_valid(yc_valid), .yd_valid(yd_valid),
    .ya_ready(ya_ready), .yb_ready(yb_ready), .yc_ready(yc_ready), .yd_ready(yd_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [7:0]  din;
    logic        dv;
    logic [3:0]  rdy;        // {d,c,b,a}
    logic        exp_rdy;    // din_ready before the edge
    logic [3:0]  exp_valid;  // {d,c,b,a} after the edge
    logic [31:0] exp_data;   // {d,c,b,a} after the edge, checked where valid
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [7:0] d, input logic dv,
                       input logic [3:0] rdy, input logic sf);
    s1 = sel[1]; s0 = sel[0]; din = d; din_valid = dv; sof = sf;
    {yd_ready, yc_ready, yb_ready, ya_ready} = rdy;
  endtask

  task automatic check_out(input string tag, input logic [3:0] ev, input logic [31:0] ed);
    logic [31:0] yall;
    yall = {yd, yc, yb, ya};
    check($sformatf("%s valid", tag), {28'd0, yd_valid, yc_valid, yb_valid, ya_valid}, {28'd0, ev});
    for (int i = 0; i < 4; i++)
      if (ev[i]) check($sformatf("%s data ch%0d", tag, i), {24'd0, yall[8*i +: 8]}, {24'd0, ed[8*i +: 8]});
  endtask

  initial begin
    //           sel    din    dv    rdy     erdy  evalid   edata {d,c,b,a}
    vecs[0]  = '{2'd2, 8'hA5, 1'b1, 4'hF,    1'b1, 4'b0100, 32'h00A5_0000};
    vecs[1]  = '{2'd2, 8'h00, 1'b0, 4'hF,    1'b1, 4'b0000, 32'h0};
    vecs[2]  = '{2'd1, 8'h01, 1'b1, 4'hF,    1'b1, 4'b0010, 32'h0000_0100};
    vecs[3]  = '{2'd1, 8'h02, 1'b1, 4'hF,    1'b1, 4'b0010, 32'h0000_0200};
    vecs[4]  = '{2'd1, 8'h03, 1'b1, 4'hF,    1'b1, 4'b0010, 32'h0000_0300};
    vecs[5]  = '{2'd1, 8'h00, 1'b0, 4'hF,    1'b1, 4'b0000, 32'h0};
    vecs[6]  = '{2'd0, 8'h11, 1'b1, 4'b0000, 1'b1, 4'b0001, 32'h0000_0011};
    vecs[7]  = '{2'd0, 8'h22, 1'b1, 4'b0000, 1'b0, 4'b0001, 32'h0000_0011};
    vecs[8]  = '{2'd3, 8'h33, 1'b1, 4'b0000, 1'b1, 4'b1001, 32'h3300_0011};
    vecs[9]  = '{2'd3, 8'h44, 1'b0, 4'b0000, 1'b0, 4'b1001, 32'h3300_0011};
    vecs[10] = '{2'd0, 8'h00, 1'b0, 4'b1001, 1'b1, 4'b0000, 32'h0};
    vecs[11] = '{2'd1, 8'h10, 1'b1, 4'b0000, 1'b1, 4'b0010, 32'h0000_1000};
    vecs[12] = '{2'd1, 8'h20, 1'b1, 4'b0010, 1'b1, 4'b0010, 32'h0000_2000};
    vecs[13] = '{2'd1, 8'h00, 1'b0, 4'hF,    1'b1, 4'b0000, 32'h0};

    rst_n = 1'b0;
    drive(2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);
    #1;
    check_out("reset", 4'b0000, 32'h0);
    check("reset data", {yd, yc, yb, ya}, 32'h0);
    check("reset din_ready", {31'd0, din_ready}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef DEMUX_AUTO_SEL_EN
    begin
      int exp_ch [6] = '{0, 1, 2, 3, 0, 1};
      for (int k = 0; k < 6; k++) begin
        drive(2'd3, 8'(8'h50 + k), 1'b1, 4'hF, (k == 4));
        #1;
        check($sformatf("auto%0d din_ready", k), {31'd0, din_ready}, 32'd1);
        @(posedge clk); #1;
        check_out($sformatf("auto%0d", k), 4'(1 << exp_ch[k]),
                  32'(32'(8'h50 + k) << (8 * exp_ch[k])));
      end
    end
`else
    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].sel, vecs[v].din, vecs[v].dv, vecs[v].rdy, 1'b0);
      #1;
      check($sformatf("vec%0d din_ready", v), {31'd0, din_ready}, {31'd0, vecs[v].exp_rdy});
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_data);
    end
`endif

    // Reset pulse to realign any slot counter, then fill all four channels with sinks stalled.
    drive(2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 8'(8'hA0 + 8'h10 * i), 1'b1, 4'b0000, 1'b0);
      @(posedge clk); #1;
    end
    check_out("fill", 4'b1111, 32'hD0C0_B0A0);
    drive(2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);
    #1;
    check("stall din_ready", {31'd0, din_ready}, 32'd0);

    // Asynchronous reset in mid-cycle while all channels are stalled FULL.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async reset", 4'b0000, 32'h0);
    check("async reset data", {yd, yc, yb, ya}, 32'h0);
    check("async reset din_ready", {31'd0, din_ready}, 32'd1);
    drive(2'd0, 8'h77, 1'b1, 4'hF, 1'b0);
    @(posedge clk); #1;
    check_out("held reset", 4'b0000, 32'h0);
    rst_n = 1'b1;
    drive(2'd0, 8'h5A, 1'b1, 4'hF, 1'b0);
    @(posedge clk); #1;
    check_out("post reset", 4'b0001, 32'h0000_005A);
    drive(2'd0, 8'h00, 1'b0, 4'hF, 1'b0);
    @(posedge clk); #1;
    check_out("post reset drain", 4'b0000, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_1to4_stream.md
DEMUX_1TO4_STREAM -- requirements
Module: demux_1to4_stream

Interface
REQ-001 Parameter W, default 8, data width of input and all four outputs.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 din  input  W  input data beat.
REQ-005 din_valid  input  1  din holds a beat.
REQ-006 din_ready  output  1  block accepts din this cycle.
REQ-007 s0, s1  input  1 each  destination select; {s1,s0} = 0..3 selects a,b,c,d; sampled with din.
REQ-008 sof  input  1  start-of-frame marker qualifying din; used only under REQ-027.
REQ-009 ya, yb, yc, yd  output  W each  channel data.
REQ-010 ya_valid, yb_valid, yc_valid, yd_valid  output  1 each  channel holds a beat.
REQ-011 ya_ready, yb_ready, yc_ready, yd_ready  input  1 each  sink takes the beat.

Function
REQ-012 Transfer occurs when valid and ready are both high at a rising clk edge, on input and on every output.
REQ-013 Each channel shall own a one-entry holding register with two states, EMPTY and FULL; y<ch>_valid = FULL.
REQ-014 EMPTY->FULL on an input transfer routed to that channel; FULL->EMPTY on an output transfer with no new routed beat; FULL->FULL on a simultaneous output transfer and routed input transfer, the register taking the new beat.
REQ-015 din_ready shall be combinational: high when the destination channel is EMPTY or its y<ch>_ready is high; independent of din_valid.
REQ-016 Latency: a beat accepted at edge N is presented on its y<ch>, with y<ch>_valid high, from edge N onward; one cycle of delay.
REQ-017 Y<ch> and y<ch>_valid shall hold stable while FULL and y<ch>_ready is low.
REQ-018 A stalled channel shall not block the other channels; din_ready depends only on the selected channel.
REQ-019 Channels drain independently; any subset of the four may complete output transfers in the same cycle.
REQ-020 Beat order within one channel is preserved; there is no ordering guarantee across channels.
REQ-021 Y<ch> data while EMPTY is don't-care; the bench shall check data only when valid.
REQ-022 No beat shall be dropped or duplicated.

Reset
REQ-023 On rst_n low, all four channels go EMPTY immediately, without waiting for clk.
REQ-024 While rst_n is low: all y<ch>_valid = 0 and all y<ch> = 0; din_ready follows REQ-015, so it reads 1.
REQ-025 A reset during a stall discards all held beats.
REQ-026 The first transfer after reset release occurs no earlier than the first rising edge with rst_n high.

Configuration
REQ-027 Macro DEMUX_AUTO_SEL_EN.
- Defined: destination comes from an internal 2-bit slot counter; s0 and s1 are ignored.
- Counter resets to 0 and advances by 1 per input transfer, wrapping 3->0.
- An input transfer with sof=1 goes to channel a, and the counter becomes 1.
- din_ready uses the counter-selected channel.
REQ-028 Macro not defined: destination is {s1,s0}, sof is ignored, and no slot counter exists.

Verification
REQ-029 Reset: rst_n low mid-stall with all channels FULL -> all y<ch>_valid = 0 asynchronously, before the next clk edge.
REQ-030 Routing: {s1,s0}=2, din=8'hA5, all readies high -> yc=8'hA5, yc_valid=1 for exactly one cycle; the other valids stay 0.
REQ-031 Back-to-back without a stall: channel b with yb_ready high receives 8'h01, 8'h02, 8'h03 on consecutive cycles -> din_ready stays 1 and yb shows 01, 02, 03 in order.
REQ-032 Isolation: ya_ready=0 with a FULL, din to a -> din_ready=0; switching the select to d -> din_ready=1, and the beat lands in yd.
REQ-033 Simultaneous load and drain: b FULL with 8'h10, yb_ready=1, new 8'h20 to b in the same cycle -> 8'h10 consumed, yb=8'h20, yb_valid stays 1.
REQ-034 Auto-select (DEMUX_AUTO_SEL_EN defined): six beats, with sof on beat 5 -> channels a, b, c, d, a, b.
